// File: rtl/lut_config_loader.sv
// Serial loader that assembles a LUT config word LSB-first and commits it with a one-cycle strobe.
// Latency: config_en asserts the cycle after the final beat is accepted.
// Backpressure: din_ready is high only in SHIFT with abort low; beats are taken on din_valid && din_ready.
module lut_config_loader #(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2**INPUTS,
    parameter int SERIAL_WIDTH = 1
) (
    input  logic                    config_clk,
    input  logic                    config_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [SERIAL_WIDTH-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [MEM_SIZE-1:0]     config_out,
    output logic                    config_en,
    output logic                    busy,
    output logic                    done
);

    localparam int BEATS = MEM_SIZE / SERIAL_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [MEM_SIZE-1:0] r_cfg;
    logic                r_done;
    logic                w_accept;
    logic                w_last;
    logic                w_launch;
    logic [MEM_SIZE-1:0] w_shifted;

    // abort masks din_ready so an abort always beats a coincident final beat
    assign din_ready  = (r_state == S_SHIFT) && !abort;
    assign w_accept   = din_ready && din_valid;
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_launch   = (r_state == S_IDLE) && start && !abort;

    assign config_out = r_cfg;
    assign config_en  = (r_state == S_COMMIT);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

    // New beat enters at the top so the first beat ends up in the low bits
    if (SERIAL_WIDTH < MEM_SIZE) begin : g_shift
        assign w_shifted = {din, r_cfg[MEM_SIZE-1:SERIAL_WIDTH]};
    end else begin : g_single
        assign w_shifted = din;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_launch) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (abort)                   w_state_nxt = S_IDLE;
                else if (w_accept && w_last) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    // Beat counter: only counts inside SHIFT, cleared everywhere else and on abort
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            r_cnt <= '0;
        end else if (r_state != S_SHIFT || abort) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Config word only moves on accepted beats
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n)  r_cfg <= '0;
        else if (w_accept)  r_cfg <= w_shifted;
    end

    // Sticky done: cleared when a load launches, set when it commits
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n)              r_done <= 1'b0;
        else if (w_launch)              r_done <= 1'b0;
        else if (r_state == S_COMMIT)   r_done <= 1'b1;
    end

endmodule

// File: tb/tb_lut_config_loader.sv
module tb_lut_config_loader;

    logic       clk;
    logic       rst_n;

    logic       a_start, a_abort, a_din, a_valid;
    logic       a_ready, a_en, a_busy, a_done;
    logic [3:0] a_cfg;

    logic        b_start, b_abort, b_valid;
    logic [1:0]  b_din;
    logic        b_ready, b_en, b_busy, b_done;
    logic [15:0] b_cfg;

    int errors = 0;
    int checks = 0;

    lut_config_loader #(.INPUTS(2), .MEM_SIZE(4), .SERIAL_WIDTH(1)) u_a (
        .config_clk(clk), .config_rst_n(rst_n), .start(a_start), .abort(a_abort),
        .din(a_din), .din_valid(a_valid), .din_ready(a_ready), .config_out(a_cfg),
        .config_en(a_en), .busy(a_busy), .done(a_done)
    );

    lut_config_loader #(.INPUTS(4), .MEM_SIZE(16), .SERIAL_WIDTH(2)) u_b (
        .config_clk(clk), .config_rst_n(rst_n), .start(b_start), .abort(b_abort),
        .din(b_din), .din_valid(b_valid), .din_ready(b_ready), .config_out(b_cfg),
        .config_en(b_en), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic d);
        a_din = d; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic a_launch();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_din = 0; a_valid = 0;
        b_start = 0; b_abort = 0; b_din = 0; b_valid = 0;
        #2;
        checks++; if ({a_cfg, a_en, a_ready, a_busy, a_done} !== 8'h00) begin
            errors++; $display("FAIL reset_a: got %b exp 00000000", {a_cfg, a_en, a_ready, a_busy, a_done});
        end
        checks++; if ({b_cfg, b_en, b_ready, b_busy, b_done} !== 20'h0) begin
            errors++; $display("FAIL reset_b: got %h exp 00000", {b_cfg, b_en, b_ready, b_busy, b_done});
        end
        #10 rst_n = 1'b1;
        tick();
        checks++; if ({a_busy, a_ready, a_en} !== 3'b000) begin
            errors++; $display("FAIL idle_after_reset: got %b exp 000", {a_busy, a_ready, a_en});
        end
    endtask

    task automatic test_back_to_back();
        a_launch();
        checks++; if ({a_busy, a_ready, a_en, a_done} !== 4'b1100) begin
            errors++; $display("FAIL b2b_shift_entry: got %b exp 1100", {a_busy, a_ready, a_en, a_done});
        end
        a_beat(1); a_beat(0); a_beat(1); a_beat(1);
        checks++; if ({a_en, a_ready, a_busy} !== 3'b101) begin
            errors++; $display("FAIL b2b_commit: got %b exp 101", {a_en, a_ready, a_busy});
        end
        checks++; if (a_cfg !== 4'b1101) begin
            errors++; $display("FAIL b2b_cfg: got %b exp 1101", a_cfg);
        end
        tick();
        checks++; if ({a_en, a_busy, a_done} !== 3'b001) begin
            errors++; $display("FAIL b2b_after_commit: got %b exp 001", {a_en, a_busy, a_done});
        end
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        int gaps [4] = '{0, 3, 1, 2};
        int pulses = 0;
        logic busy_ok = 1'b1;
        bits = 4'b1101;
        a_launch();
        checks++; if (a_done !== 1'b0) begin
            errors++; $display("FAIL gaps_done_cleared: got %b exp 0", a_done);
        end
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                a_din = ~bits[i]; a_valid = 1'b0;
                tick();
                if (a_busy !== 1'b1) busy_ok = 1'b0;
                if (a_en === 1'b1) pulses++;
            end
            a_beat(bits[i]);
            if (a_en === 1'b1) pulses++;
            if (i < 3 && a_busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++; if (a_cfg !== 4'b1101) begin
            errors++; $display("FAIL gaps_cfg: got %b exp 1101", a_cfg);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (a_en === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin
            errors++; $display("FAIL gaps_pulses: got %0d exp 1", pulses);
        end
        checks++; if (busy_ok !== 1'b1) begin
            errors++; $display("FAIL gaps_busy: got %b exp 1", busy_ok);
        end
        checks++; if (a_done !== 1'b1) begin
            errors++; $display("FAIL gaps_done: got %b exp 1", a_done);
        end
    endtask

    task automatic test_abort();
        // First run: abort after two beats (cfg 1101 -> 0110 -> 1011)
        a_launch();
        a_beat(0); a_beat(1);
        a_abort = 1'b1; a_din = 1'b0; a_valid = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b0) begin
            errors++; $display("FAIL abort_ready_mask: got %b exp 0", a_ready);
        end
        tick();
        a_abort = 1'b0; a_valid = 1'b0;
        checks++; if ({a_busy, a_en, a_done} !== 3'b000) begin
            errors++; $display("FAIL abort1_state: got %b exp 000", {a_busy, a_en, a_done});
        end
        checks++; if (a_cfg !== 4'b1011) begin
            errors++; $display("FAIL abort1_cfg: got %b exp 1011", a_cfg);
        end
        // Second run: abort coincident with final beat (1011 -> 1101 -> 1110 -> 1111)
        a_launch();
        a_beat(1); a_beat(1); a_beat(1);
        a_abort = 1'b1; a_din = 1'b0; a_valid = 1'b1;
        tick();
        a_abort = 1'b0; a_valid = 1'b0;
        checks++; if ({a_busy, a_en, a_done} !== 3'b000) begin
            errors++; $display("FAIL abort2_state: got %b exp 000", {a_busy, a_en, a_done});
        end
        checks++; if (a_cfg !== 4'b1111) begin
            errors++; $display("FAIL abort2_cfg: got %b exp 1111", a_cfg);
        end
        tick();
        checks++; if ({a_en, a_busy} !== 2'b00) begin
            errors++; $display("FAIL abort2_no_pulse: got %b exp 00", {a_en, a_busy});
        end
    endtask

    task automatic test_async_reset();
        a_launch();
        a_beat(1); a_beat(1);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({a_cfg, a_en, a_ready, a_busy, a_done} !== 8'h00) begin
            errors++; $display("FAIL async_reset: got %b exp 00000000", {a_cfg, a_en, a_ready, a_busy, a_done});
        end
        #2 rst_n = 1'b1;
        tick();
        checks++; if ({a_busy, a_en} !== 2'b00) begin
            errors++; $display("FAIL async_reset_idle: got %b exp 00", {a_busy, a_en});
        end
        a_launch();
        a_beat(0); a_beat(1); a_beat(1); a_beat(0);
        checks++; if ({a_cfg, a_en} !== 5'b0110_1) begin
            errors++; $display("FAIL reload_commit: got %b exp 01101", {a_cfg, a_en});
        end
        tick();
        checks++; if (a_done !== 1'b1) begin
            errors++; $display("FAIL reload_done: got %b exp 1", a_done);
        end
    endtask

    task automatic test_wide();
        logic [1:0] beats [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_din = beats[i]; b_valid = 1'b1;
            tick();
        end
        b_valid = 1'b0;
        checks++; if ({b_cfg, b_en} !== {16'h3939, 1'b1}) begin
            errors++; $display("FAIL wide_commit: got %h/%b exp 3939/1", b_cfg, b_en);
        end
        // abort during COMMIT must not stop the commit
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        checks++; if ({b_en, b_busy, b_done} !== 3'b001) begin
            errors++; $display("FAIL wide_after_commit: got %b exp 001", {b_en, b_busy, b_done});
        end
        // start together with abort in IDLE: stay IDLE
        b_start = 1'b1; b_abort = 1'b1;
        tick();
        b_start = 1'b0; b_abort = 1'b0;
        checks++; if ({b_busy, b_done} !== 2'b01) begin
            errors++; $display("FAIL wide_start_abort_idle: got %b exp 01", {b_busy, b_done});
        end
    endtask

    task automatic test_start_held();
        int pulses = 0;
        a_start = 1'b1;
        tick();
        a_beat(1); a_beat(0); a_beat(0); a_beat(1);
        if (a_en === 1'b1) pulses++;
        checks++; if (a_cfg !== 4'b1001) begin
            errors++; $display("FAIL held_cfg: got %b exp 1001", a_cfg);
        end
        tick();
        if (a_en === 1'b1) pulses++;
        checks++; if ({a_busy, a_done} !== 2'b01) begin
            errors++; $display("FAIL held_back_to_idle: got %b exp 01", {a_busy, a_done});
        end
        tick();
        if (a_en === 1'b1) pulses++;
        checks++; if ({a_busy, a_done, a_ready} !== 3'b101) begin
            errors++; $display("FAIL held_relaunch: got %b exp 101", {a_busy, a_done, a_ready});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (a_en === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin
            errors++; $display("FAIL held_pulses: got %0d exp 1", pulses);
        end
        a_start = 1'b0; a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        checks++; if (a_busy !== 1'b0) begin
            errors++; $display("FAIL held_cleanup: got %b exp 0", a_busy);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_async_reset();
        test_wide();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
